// File: rtl/run_scan_ctrl_pkg.sv
// run_scan_ctrl_pkg: shared FSM states and run-detector encodings for the word-level run scanner.
package run_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;
  localparam int RUN_LEN = 4;
  localparam logic [3:0] D_INIT = 4'd0;
  localparam logic [3:0] D_Z1 = 4'd1;
  localparam logic [3:0] D_Z2 = 4'd2;
  localparam logic [3:0] D_Z3 = 4'd3;
  localparam logic [3:0] D_Z4 = D_Z1 + 4'(RUN_LEN - 1);
  localparam logic [3:0] D_O1 = 4'd5;
  localparam logic [3:0] D_O2 = 4'd6;
  localparam logic [3:0] D_O3 = 4'd7;
  localparam logic [3:0] D_O4 = D_O1 + 4'(RUN_LEN - 1);
endpackage

// File: rtl/run_scan_ctrl_detector.sv
// run_detector: Moore detector, z=1 while the last RUN_LEN applied bits are all equal.
module run_detector
  import run_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic w,
  output logic z
);
  logic [3:0] q, q_nxt;
  always_comb begin
    q_nxt = w ? ((q >= D_O1 && q < D_O4) ? q + 4'd1 : (q == D_O4 ? D_O4 : D_O1))
              : ((q >= D_Z1 && q < D_Z4) ? q + 4'd1 : (q == D_Z4 ? D_Z4 : D_Z1));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= D_INIT;
    else q <= clr ? D_INIT : q_nxt;
  end
  assign z = (q == D_Z4) || (q == D_O4);
endmodule

// File: rtl/run_scan_ctrl.sv
// run_scan_ctrl: shifts a latched word MSB-first through run_detector and reports run count/first index.
module run_scan_ctrl
  import run_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] first_idx
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state, next;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] bit_cnt, idx_d;
  logic valid_d, clr, z, accept, cancel;
  run_detector u_det (.clk(clk), .reset(reset), .clr(clr), .w(sr[WIDTH-1]), .z(z));
  always_comb begin
    next = state;
    clr = 1'b0;
    case (state)
      IDLE: begin
        next = start ? SHIFT : IDLE;
        clr = start;
      end
      SHIFT: next = abort ? IDLE : (bit_cnt == LAST ? DRAIN : SHIFT);
      DRAIN: next = abort ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  assign accept = (state == IDLE) && start;
  assign cancel = (state == SHIFT || state == DRAIN) && abort;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      idx_d <= '0;
      valid_d <= 1'b0;
      found <= 1'b0;
      match_count <= '0;
      first_idx <= '0;
    end else begin
      state <= next;
      valid_d <= (state == SHIFT) && !abort;
      idx_d <= bit_cnt;
      if (accept || cancel) begin
        if (accept) sr <= din;
        bit_cnt <= '0;
        found <= 1'b0;
        match_count <= '0;
        first_idx <= '0;
      end else begin
        if (state == SHIFT) begin
          sr <= sr << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        // z reflects the bit applied one edge earlier, tagged by the delayed index
        if (valid_d && z) begin
          match_count <= match_count + CNT_W'(1);
          if (!found) begin
            found <= 1'b1;
            first_idx <= idx_d;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_run_scan_ctrl.sv
// tb_run_scan_ctrl: directed vector table plus abort, ignored-start and async-reset sequences.
module tb_run_scan_ctrl;
  logic clk = 1'b0, reset, start, abort;
  logic [15:0] din;
  logic busy, done, found;
  logic [4:0] match_count, first_idx;
  int n_vec = 0, n_err = 0;
  int lat, saw;
  logic bm;
  typedef struct {
    logic [15:0] din;
    int cnt;
    int fnd;
    int first;
  } vec_t;
  vec_t tbl[5];
  run_scan_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
    .busy(busy), .done(done), .found(found), .match_count(match_count), .first_idx(first_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic scan(input logic [15:0] d, input int inj_at, input logic [15:0] inj_din,
                      output int l, output logic b);
    @(negedge clk);
    din = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l = -1;
    b = 1'b0;
    for (int i = 1; i <= 40 && l < 0; i++) begin
      if (i == inj_at) begin
        din = inj_din;
        start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (i == 5) b = busy;
      if (done) l = i;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic watch_no_done(output int s);
    s = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (done) s = 1;
    end
  endtask
  initial begin
    tbl[0] = '{16'hFFFF, 13, 1, 3};
    tbl[1] = '{16'hAAAA, 0, 0, 0};
    tbl[2] = '{16'h0FF0, 7, 1, 3};
    tbl[3] = '{16'h8421, 3, 1, 4};
    tbl[4] = '{16'hF0F0, 4, 1, 3};
    reset = 1'b1; start = 1'b0; abort = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_count", match_count, 0);
    chk("rst_first", first_idx, 0);
    @(negedge clk) reset = 1'b0;
    for (int v = 0; v < 5; v++) begin
      scan(tbl[v].din, 0, 16'h0, lat, bm);
      chk("latency", lat, 17);
      chk("busy_mid", bm, 1);
      chk("count", match_count, tbl[v].cnt);
      chk("found", found, tbl[v].fnd);
      chk("first_idx", first_idx, tbl[v].first);
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
    end
    // abort mid-SHIFT after one run was already counted
    @(negedge clk);
    din = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_count", match_count, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_count", match_count, 0);
    chk("abort_found", found, 0);
    chk("abort_first", first_idx, 0);
    watch_no_done(saw);
    chk("abort_no_done", saw, 0);
    // start re-pulsed mid-scan must be ignored
    scan(16'h0FF0, 5, 16'hFFFF, lat, bm);
    chk("restart_latency", lat, 17);
    chk("restart_count", match_count, 7);
    chk("restart_first", first_idx, 3);
    // async reset between clock edges
    @(negedge clk);
    din = 16'h0FF0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_count", match_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_count", match_count, 0);
    chk("areset_found", found, 0);
    chk("areset_first", first_idx, 0);
    @(negedge clk) reset = 1'b0;
    watch_no_done(saw);
    chk("reset_no_done", saw, 0);
    scan(16'h0000, 0, 16'h0, lat, bm);
    chk("zero_latency", lat, 17);
    chk("zero_count", match_count, 13);
    chk("zero_found", found, 1);
    chk("zero_first", first_idx, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
